// File: rtl/muldiv_sched_pkg.sv
// Shared encodings for the E-stage multiply/divide sequencer: decode fields,
// FSM state codes and the internal arithmetic op selector.
package muldiv_sched_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        HL_LO   = 2'b00,
        HL_HI   = 2'b01,
        HL_MADD = 2'b10
    } hl_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // MADD arrives on the HI/LO write path, so the datapath needs its own op code.
    typedef enum logic [2:0] {
        AR_MULTU = 3'd0,
        AR_MULT  = 3'd1,
        AR_DIVU  = 3'd2,
        AR_DIV   = 3'd3,
        AR_MADD  = 3'd4
    } ar_op_e;

    function automatic logic ar_is_div(input ar_op_e op);
        return (op == AR_DIVU) || (op == AR_DIV);
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_sched_md_arith.sv
// Combinational 64-bit multiply/divide datapath producing {hi,lo}, including
// the divide-by-zero and signed-overflow result rules.
module md_arith
    import muldiv_sched_pkg::*;
(
    input  ar_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [63:0] hilo_i,
    output logic [63:0] res_o
);

    logic [63:0] uprod_s;
    logic [63:0] sprod_s;
    logic [31:0] b_safe_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] mq_s;
    logic [31:0] mr_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;
    logic        b_zero_s;

    assign uprod_s  = {32'd0, a_i} * {32'd0, b_i};
    assign sprod_s  = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});

    // Divisor forced non-zero so the dividers never see 0; the result is overridden anyway.
    assign b_zero_s = (b_i == 32'd0);
    assign b_safe_s = b_zero_s ? 32'd1 : b_i;
    assign uq_s     = a_i / b_safe_s;
    assign ur_s     = a_i % b_safe_s;

    // Signed divide on magnitudes: 0x80000000/-1 yields 0x80000000 rem 0 without a special case.
    assign mag_a_s  = abs32(a_i);
    assign mag_b_s  = abs32(b_safe_s);
    assign mq_s     = mag_a_s / mag_b_s;
    assign mr_s     = mag_a_s % mag_b_s;
    assign sq_s     = (a_i[31] ^ b_safe_s[31]) ? (32'd0 - mq_s) : mq_s;
    assign sr_s     = a_i[31] ? (32'd0 - mr_s) : mr_s;

    // Select the result for the requested op.
    always_comb begin
        res_o = 64'd0;
        case (op_i)
            AR_MULTU: res_o = uprod_s;
            AR_MULT:  res_o = sprod_s;
            AR_MADD:  res_o = hilo_i + sprod_s;
            AR_DIVU: begin
                if (b_zero_s) begin
                    res_o = {a_i, 32'hFFFF_FFFF};
                end else begin
                    res_o = {ur_s, uq_s};
                end
            end
            AR_DIV: begin
                if (b_zero_s) begin
                    res_o = {a_i, 32'hFFFF_FFFF};
                end else begin
                    res_o = {sr_s, sq_s};
                end
            end
            default: res_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/muldiv_sched.sv
// E-stage multiply/divide sequencer owning HI/LO; runs fixed-latency ops and
// raises the D-stage stall. Optional exception flush input when MD_CANCEL_EN is defined.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mulOp,
    input  logic        mulWe,
    input  logic [1:0]  HiLo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [63:0]        res_q;

    ar_op_e             ar_op_d;
    logic [CNT_W-1:0]   cnt_load_d;
    logic [63:0]        ar_res_s;
    logic               cancel_s;
    logic               madd_req_s;
    logic               launch_s;

`ifdef MD_CANCEL_EN
    assign cancel_s = cancel;
`else
    assign cancel_s = 1'b0;
`endif

    assign madd_req_s = mulWe & (HiLo == HL_MADD);
    assign launch_s   = (state_q == ST_IDLE) & ~cancel_s & (start | madd_req_s);

    // Decode the launching op; start takes priority over a simultaneous HI/LO write.
    always_comb begin
        ar_op_d = AR_MADD;
        if (start) begin
            case (mulOp)
                MD_MULTU: ar_op_d = AR_MULTU;
                MD_MULT:  ar_op_d = AR_MULT;
                MD_DIVU:  ar_op_d = AR_DIVU;
                MD_DIV:   ar_op_d = AR_DIV;
                default:  ar_op_d = AR_MULTU;
            endcase
        end else begin
            ar_op_d = AR_MADD;
        end
        if (ar_is_div(ar_op_d)) begin
            cnt_load_d = CNT_W'(DIV_CYCLES);
        end else begin
            cnt_load_d = CNT_W'(MUL_CYCLES);
        end
    end

    md_arith u_md_arith (
        .op_i   (ar_op_d),
        .a_i    (rs_val),
        .b_i    (rt_val),
        .hilo_i ({hi_q, lo_q}),
        .res_o  (ar_res_s)
    );

    // Sequencer FSM: the result is captured at launch and released to HI/LO on the final busy edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            res_q   <= 64'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (launch_s) begin
                        state_q <= ST_RUN;
                        cnt_q   <= cnt_load_d;
                        busy_q  <= 1'b1;
                        res_q   <= ar_res_s;
                    end else if (mulWe && !start && !cancel_s) begin
                        case (HiLo)
                            HL_LO:   lo_q <= rs_val;
                            HL_HI:   hi_q <= rs_val;
                            default: hi_q <= hi_q;
                        endcase
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cancel_s) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        hi_q    <= res_q[63:32];
                        lo_q    <= res_q[31:0];
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Stall is combinational so a consumer in D is held in the very cycle an op issues.
    assign stall = md_use_D & (busy_q | start | madd_req_s);
    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: expected {hi,lo} pushed at issue, popped when busy drops.
module tb_muldiv_sched;

    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mulOp;
    logic        mulWe;
    logic [1:0]  HiLo;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
`ifdef MD_CANCEL_EN
    logic        cancel;
`endif
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] exp_q[$];
    logic [63:0] mdl_hilo;
    int          n_chk = 0;
    int          n_err = 0;
    int          illegal_cnt = 0;

    always #5 clk = ~clk;

    muldiv_sched #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mulOp    (mulOp),
        .mulWe    (mulWe),
        .HiLo     (HiLo),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_use_D (md_use_D),
`ifdef MD_CANCEL_EN
        .cancel   (cancel),
`endif
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always @(posedge clk) begin
        if (!reset && busy && (start || mulWe)) illegal_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // kind: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MADD
    function automatic logic [63:0] ref_result(input int kind, input logic [31:0] a, input logic [31:0] b,
                                               input logic [63:0] acc);
        longint sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (kind)
            0: return ua * ub;
            1: return 64'(sa * sb);
            4: return acc + 64'(sa * sb);
            2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic launch(input int kind, input logic [31:0] a, input logic [31:0] b, input bit with_we);
        logic [63:0] e;
        @(negedge clk);
        e = ref_result(kind, a, b, mdl_hilo);
        exp_q.push_back(e);
        mdl_hilo = e;
        rs_val = a;
        rt_val = b;
        if (kind == 4) begin
            mulWe = 1'b1;
            HiLo  = 2'b10;
        end else begin
            start = 1'b1;
            mulOp = 2'(kind);
            mulWe = with_we;
            HiLo  = 2'b10;
        end
        @(negedge clk);
        start = 1'b0;
        mulWe = 1'b0;
    endtask

    task automatic finish_op(input string tag, input int n);
        int cyc;
        logic [63:0] e;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check_eq({tag, "_lat"}, 64'(cyc), 64'(n));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check_eq({tag, "_hilo"}, {hi, lo}, e);
    endtask

    task automatic mt(input string tag, input logic [1:0] sel, input logic [31:0] v);
        @(negedge clk);
        mulWe  = 1'b1;
        HiLo   = sel;
        rs_val = v;
        @(negedge clk);
        mulWe  = 1'b0;
        if (sel == 2'b00) mdl_hilo[31:0] = v;
        else mdl_hilo[63:32] = v;
        check_eq({tag, "_val"}, (sel == 2'b00) ? 64'(lo) : 64'(hi), 64'(v));
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check_eq({tag, "_busy2"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        int kind;
        logic [31:0] a, b;
        logic [63:0] e;
        logic [63:0] pre;
        reset = 1'b1; start = 1'b0; mulOp = 2'b00; mulWe = 1'b0; HiLo = 2'b00;
        rs_val = 32'd0; rt_val = 32'd0; md_use_D = 1'b0; mdl_hilo = 64'd0;
`ifdef MD_CANCEL_EN
        cancel = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_hilo", {hi, lo}, 64'd0);
        check_eq("rst_stall", 64'(stall), 64'd0);
        reset = 1'b0;

        launch(0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        finish_op("multu", MULC);
        check_eq("multu_spec", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        launch(1, 32'hFFFF_FFFD, 32'd4, 1'b0);
        finish_op("mult", MULC);
        check_eq("mult_spec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF4);
        launch(3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        finish_op("div", DIVC);
        check_eq("div_spec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        launch(2, 32'd5, 32'd0, 1'b0);
        finish_op("divu0", DIVC);
        check_eq("divu0_spec", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        launch(3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        finish_op("divovf", DIVC);
        check_eq("divovf_spec", {hi, lo}, 64'h0000_0000_8000_0000);

        mt("mtlo", 2'b00, 32'h0000_1234);
        mt("mtlo2", 2'b00, 32'hFFFF_FFFF);
        mt("mthi", 2'b01, 32'h0000_0000);
        launch(4, 32'd1, 32'd1, 1'b0);
        finish_op("madd", MULC);
        check_eq("madd_spec", {hi, lo}, 64'h0000_0001_0000_0000);
        launch(0, 32'd3, 32'd4, 1'b1);
        finish_op("start_wins", MULC);

        for (int i = 0; i < 8; i++) begin
            kind = int'($urandom_range(0, 4));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            launch(kind, a, b, 1'b0);
            finish_op("rand", (kind == 2 || kind == 3) ? DIVC : MULC);
        end

        // stall through a DIV, with an illegal start pulse mid-op
        md_use_D = 1'b1;
        @(negedge clk);
        a = 32'd100; b = 32'hFFFF_FFF9;
        e = ref_result(3, a, b, mdl_hilo);
        exp_q.push_back(e);
        mdl_hilo = e;
        start = 1'b1; mulOp = 2'b11; rs_val = a; rt_val = b;
        #1 check_eq("stall_launch", 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            check_eq("stall_busy", 64'(stall), 64'd1);
            cyc++;
            if (cyc == 3) begin
                start = 1'b1; mulOp = 2'b00; rs_val = 32'd7; rt_val = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        #1;
        check_eq("stall_lat", 64'(cyc), 64'(DIVC));
        check_eq("stall_after", 64'(stall), 64'd0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check_eq("stall_hilo", {hi, lo}, e);
        md_use_D = 1'b0;

        // reset during busy cycle 3
        launch(3, 32'd1000, 32'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_hilo", {hi, lo}, 64'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        mdl_hilo = 64'd0;

`ifdef MD_CANCEL_EN
        mt("c_mthi", 2'b01, 32'h0000_AAAA);
        mt("c_mtlo", 2'b00, 32'h0000_5555);
        pre = mdl_hilo;
        launch(1, 32'd3, 32'd3, 1'b0);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check_eq("cancel_busy", 64'(busy), 64'd0);
        check_eq("cancel_hilo", {hi, lo}, pre);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        mdl_hilo = pre;
        @(negedge clk);
        cancel = 1'b1; start = 1'b1; mulOp = 2'b00; rs_val = 32'd9; rt_val = 32'd9;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        check_eq("cancel_launch", 64'(busy), 64'd0);
        cancel = 1'b1; mulWe = 1'b1; HiLo = 2'b00; rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        cancel = 1'b0; mulWe = 1'b0;
        check_eq("cancel_mt", {hi, lo}, pre);
`else
        pre = mdl_hilo;
        check_eq("post_rst_hilo", {hi, lo}, pre);
`endif

        check_eq("illegal_issue", 64'(illegal_cnt), 64'd1);
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
